// File: rtl/wb_uart_pkg.sv
// Shared constants and types for the Wishbone UART transmitter.
package wb_uart_pkg;

  // Register offsets, word index taken from adr[3:2]
  localparam logic [1:0] OFS_DATA   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_DIV    = 2'd2;
  localparam logic [1:0] OFS_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int STS_BUSY    = 0;
  localparam int STS_EMPTY   = 1;
  localparam int STS_FULL    = 2;
  localparam int STS_OVF     = 3;
  localparam int STS_LVL_LSB = 4;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  // Reset values
  localparam int         DIV_RST  = 207;
  localparam logic [1:0] CTRL_RST = 2'b00;

  // Serialiser states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/wb_uart_if.sv
// Wishbone classic slave bundle between the management SoC and the UART.
interface wb_uart_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_uart_fifo.sv
// Synchronous first-word-fall-through FIFO; pushes while full are dropped.
module wb_uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // full/empty come straight from the registered count, so a push on the
  // same edge as a pop from a full FIFO is still rejected
  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_level   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage array; contents need no reset, pointers define validity
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy tracking; reset flushes the queue
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone-slave 8N1 UART transmitter: register block, TX FIFO, baud FSM.
module wb_uart_tx
  import wb_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          DIV_WIDTH  = 16
) (
  input  logic     wb_clk_i,
  input  logic     wb_rst_ni,
  wb_uart_if.slave wbs,
  output logic     tx_o,
  output logic     tx_oeb_o,
  output logic     irq_o
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // Bus side
  logic                 w_req;
  logic                 w_acc;
  logic                 w_wr;
  logic [1:0]           w_ofs;
  logic                 w_push;
  logic [31:0]          w_rdata;
  logic [31:0]          w_div_merge;
  logic                 w_unused;
  logic                 r_ack;
  logic [31:0]          r_dat;

  // Registers
  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_en;
  logic                 r_irq_en;
  logic                 r_ovf;
  logic                 r_oeb;
  logic                 r_irq;

  // FIFO
  logic [7:0]           w_fifo_rdata;
  logic                 w_full;
  logic                 w_empty;
  logic [LVL_W-1:0]     w_level;

  // Serialiser
  tx_state_e            r_state;
  tx_state_e            w_state_nxt;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [2:0]           r_bit;
  logic [7:0]           r_shift;
  logic                 r_tx;
  logic                 w_tick;
  logic                 w_pop;
  logic                 w_reload;
  logic                 w_shift_en;
  logic                 w_tx_nxt;

  // A request is only accepted when ack is low, which both limits ack to one
  // cycle and keeps it from firing on back-to-back cycles
  assign w_req  = wbs.wbs_stb_i && wbs.wbs_cyc_i &&
                  (wbs.wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign w_acc  = w_req && !r_ack;
  assign w_wr   = w_acc && wbs.wbs_we_i;
  assign w_ofs  = wbs.wbs_adr_i[3:2];
  assign w_push = w_wr && (w_ofs == OFS_DATA) && wbs.wbs_sel_i[0];

  // Address bits below the word and bus bits beyond the registers are ignored
  assign w_unused = ^{wbs.wbs_adr_i[1:0], w_div_merge};

  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;
  assign tx_o          = r_tx;
  assign tx_oeb_o      = r_oeb;
  assign irq_o         = r_irq;

  wb_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_push  (w_push),
    .i_wdata (wbs.wbs_dat_i[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // DIV write honours byte lanes; lanes above DIV_WIDTH fall off on commit
  always_comb begin
    w_div_merge = 32'(r_div);
    for (int b = 0; b < 4; b++)
      if (wbs.wbs_sel_i[b]) w_div_merge[8*b +: 8] = wbs.wbs_dat_i[8*b +: 8];
  end

  // Read mux; unused bits and the write-only DATA register read as zero
  always_comb begin
    w_rdata = '0;
    case (w_ofs)
      OFS_STATUS: begin
        w_rdata[STS_BUSY]            = (r_state != IDLE);
        w_rdata[STS_EMPTY]           = w_empty;
        w_rdata[STS_FULL]            = w_full;
        w_rdata[STS_OVF]             = r_ovf;
        w_rdata[STS_LVL_LSB +: 4]    = 4'(w_level);
      end
      OFS_DIV:  w_rdata[DIV_WIDTH-1:0] = r_div;
      OFS_CTRL: begin
        w_rdata[CTRL_EN]     = r_en;
        w_rdata[CTRL_IRQ_EN] = r_irq_en;
      end
      default:  w_rdata = '0;
    endcase
  end

  // Bus handshake, register writes and registered pad/irq outputs
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_div    <= DIV_WIDTH'(DIV_RST);
      r_en     <= CTRL_RST[CTRL_EN];
      r_irq_en <= CTRL_RST[CTRL_IRQ_EN];
      r_ovf    <= 1'b0;
      r_oeb    <= 1'b1;
      r_irq    <= 1'b0;
    end else begin
      r_ack <= w_acc;
      r_dat <= (w_acc && !wbs.wbs_we_i) ? w_rdata : '0;
      if (w_push && w_full)
        r_ovf <= 1'b1;
      else if (w_wr && (w_ofs == OFS_STATUS) && wbs.wbs_sel_i[0] &&
               wbs.wbs_dat_i[STS_OVF])
        r_ovf <= 1'b0;
      if (w_wr && (w_ofs == OFS_DIV))
        r_div <= w_div_merge[DIV_WIDTH-1:0];
      if (w_wr && (w_ofs == OFS_CTRL) && wbs.wbs_sel_i[0]) begin
        r_en     <= wbs.wbs_dat_i[CTRL_EN];
        r_irq_en <= wbs.wbs_dat_i[CTRL_IRQ_EN];
      end
      r_oeb <= ~r_en;
      r_irq <= r_irq_en && w_empty && (r_state == IDLE);
    end
  end

  assign w_tick = (r_cnt == '0);

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  // FSM next state; STOP chains straight into START when more data waits
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_en && !w_empty)          w_state_nxt = START;
      START:   if (w_tick)                    w_state_nxt = DATA;
      DATA:    if (w_tick && r_bit == 3'd7)   w_state_nxt = STOP;
      STOP:    if (w_tick) w_state_nxt = (r_en && !w_empty) ? START : IDLE;
      default:                                w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: pop on frame start, counter reload at bit boundaries, and
  // the line level for the coming cycle so tx_o can be a flop
  always_comb begin
    w_pop      = (w_state_nxt == START) && (r_state != START);
    w_reload   = w_pop || ((r_state != IDLE) && w_tick);
    w_shift_en = (r_state == DATA) && w_tick;
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_en ? r_shift[1] : r_shift[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  // Baud down-counter, bit index, shift register and line flop; DIV is
  // sampled only on reload so a mid-frame change lands on the next bit
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_tx <= w_tx_nxt;
      if (w_reload)     r_cnt <= r_div;
      else if (!w_tick) r_cnt <= r_cnt - 1'b1;
      if (w_pop) begin
        r_shift <= w_fifo_rdata;
        r_bit   <= '0;
      end else if (w_shift_en) begin
        r_shift <= {1'b0, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Self-checking bench for wb_uart_tx: directed register/timing checks plus
// randomized frames compared against bit patterns built from each byte.
module tb_wb_uart_tx;
  import wb_uart_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tx_o, tx_oeb, irq;
  logic prev_ack = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  wb_uart_if bus ();

  wb_uart_tx #(
    .BASE_ADR   (BASE),
    .FIFO_DEPTH (8),
    .DIV_WIDTH  (16)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs       (bus),
    .tx_o      (tx_o),
    .tx_oeb_o  (tx_oeb),
    .irq_o     (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] ofs,
                         input logic [31:0] wdat, output logic [31:0] rdat);
    int t;
    @(posedge clk); #1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = BASE + ofs;
    bus.wbs_dat_i = wdat;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!bus.wbs_ack_o && t < 20);
    if (!bus.wbs_ack_o) chk("wb ack timeout", 32'd0, 32'd1);
    rdat = bus.wbs_dat_o;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] ofs, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, ofs, d, dummy);
  endtask

  task automatic wb_rd(input logic [31:0] ofs, output logic [31:0] d);
    wb_xfer(1'b0, ofs, 32'd0, d);
  endtask

  // Expected line: start 0, data LSB first, stop 1, each held div+1 cycles
  task automatic check_frame(input logic [7:0] b, input int div);
    logic [9:0] bits;
    int ok;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ok = 0;
      for (int c = 0; c <= div; c++) begin
        @(negedge clk);
        if (tx_o === bits[i]) ok++;
      end
      chk($sformatf("frame %02h bit %0d", b, i), ok, div + 1);
    end
  endtask

  task automatic check_idle(input int cycles);
    int ok;
    ok = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (tx_o === 1'b1) ok++;
    end
    chk("line idle", ok, cycles);
  endtask

  // Bus protocol watch: ack never two cycles running, dat_o zero without ack
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wbs_ack_o) chk("ack single cycle", {31'd0, prev_ack}, 32'd0);
      else               chk("dat_o idle zero", bus.wbs_dat_o, 32'd0);
    end
    prev_ack <= bus.wbs_ack_o;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  bytes [8];
    logic [7:0]  b;
    int          div, n, hits, got;

    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'd0;
    bus.wbs_dat_i = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    chk("rst dat", bus.wbs_dat_o, 32'd0);
    chk("rst tx", {31'd0, tx_o}, 32'd1);
    chk("rst oeb", {31'd0, tx_oeb}, 32'd1);
    chk("rst irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    wb_rd(32'h8, rd); chk("rst DIV", rd, 32'h0000_00CF);
    wb_rd(32'hC, rd); chk("rst CTRL", rd, 32'h0);
    wb_rd(32'h4, rd); chk("rst STATUS", rd, 32'h2);

    // Single directed frame, DIV=3
    wb_wr(32'h8, 32'd3);
    wb_wr(32'hC, 32'd1);
    wb_wr(32'h0, 32'hA5);
    @(negedge clk); chk("tx high at ack", {31'd0, tx_o}, 32'd1);
    check_frame(8'hA5, 3);
    chk("oeb enabled", {31'd0, tx_oeb}, 32'd0);
    check_idle(4);
    wb_rd(32'h4, rd); chk("status after frame", rd, 32'h2);

    // Overflow: nine pushes with transmitter disabled
    wb_wr(32'hC, 32'd0);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (i < 8) bytes[i] = b;
      wb_wr(32'h0, {24'd0, b});
    end
    wb_rd(32'h4, rd);
    chk("ovf full", {31'd0, rd[STS_FULL]}, 32'd1);
    chk("ovf level", {28'd0, rd[7:4]}, 32'd8);
    chk("ovf sticky", {31'd0, rd[STS_OVF]}, 32'd1);
    chk("ovf not busy", {31'd0, rd[STS_BUSY]}, 32'd0);
    wb_wr(32'h4, 32'h8);
    wb_rd(32'h4, rd);
    chk("ovf cleared", {31'd0, rd[STS_OVF]}, 32'd0);
    chk("ovf level kept", {28'd0, rd[7:4]}, 32'd8);
    // Drain at DIV=0: frames must run back to back, ninth byte never sent
    wb_wr(32'h8, 32'd0);
    wb_wr(32'hC, 32'd1);
    @(negedge clk); chk("tx high at enable", {31'd0, tx_o}, 32'd1);
    for (int i = 0; i < 8; i++) check_frame(bytes[i], 0);
    check_idle(3);
    wb_rd(32'h4, rd); chk("status drained", rd, 32'h2);

    // Interrupt behaviour
    wb_wr(32'h8, 32'd1);
    wb_wr(32'hC, 32'd3);
    @(negedge clk); @(negedge clk);
    chk("irq idle empty", {31'd0, irq}, 32'd1);
    b = 8'($urandom);
    wb_wr(32'h0, {24'd0, b});
    @(negedge clk); chk("tx high before irq frame", {31'd0, tx_o}, 32'd1);
    hits = 0;
    fork
      check_frame(b, 1);
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (irq) hits++;
        end
      end
    join
    chk("irq quiet in frame", hits, 0);
    got = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (irq) got = 1;
    end
    chk("irq after stop", got, 1);
    wb_wr(32'hC, 32'd1);
    @(negedge clk); @(negedge clk);
    chk("irq masked", {31'd0, irq}, 32'd0);

    // Randomized trials; odd trials disable mid-frame and resume later
    for (int t = 0; t < 6; t++) begin
      div = $urandom_range(0, 4);
      n   = $urandom_range(1, 6);
      wb_wr(32'hC, 32'd0);
      wb_wr(32'h8, div);
      for (int i = 0; i < n; i++) begin
        bytes[i] = 8'($urandom);
        wb_wr(32'h0, {24'd0, bytes[i]});
      end
      wb_rd(32'h4, rd);
      chk("trial level", {28'd0, rd[7:4]}, n);
      chk("trial busy", {31'd0, rd[STS_BUSY]}, 32'd0);
      wb_wr(32'hC, 32'd1);
      @(negedge clk); chk("trial tx pre", {31'd0, tx_o}, 32'd1);
      if (t % 2 == 1) begin
        fork
          check_frame(bytes[0], div);
          wb_wr(32'hC, 32'd0);
        join
        check_idle(div + 3);
        chk("oeb after disable", {31'd0, tx_oeb}, 32'd1);
        wb_rd(32'h4, rd);
        chk("retained level", {28'd0, rd[7:4]}, n - 1);
        chk("idle after disable", {31'd0, rd[STS_BUSY]}, 32'd0);
        if (n > 1) begin
          wb_wr(32'hC, 32'd1);
          @(negedge clk); chk("resume tx pre", {31'd0, tx_o}, 32'd1);
          for (int i = 1; i < n; i++) check_frame(bytes[i], div);
        end
      end else begin
        for (int i = 0; i < n; i++) check_frame(bytes[i], div);
      end
      check_idle(3);
      wb_rd(32'h4, rd); chk("trial drained", rd, 32'h2);
    end

    // Address outside the register window is never acknowledged
    @(posedge clk); #1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = BASE + 32'h10;
    hits = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) hits++;
    end
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    chk("no ack out of window", hits, 0);

    // Reset in the middle of a data bit with bytes still queued
    wb_wr(32'hC, 32'd0);
    wb_wr(32'h8, 32'd3);
    for (int i = 0; i < 3; i++) wb_wr(32'h0, 32'($urandom_range(0, 255)));
    wb_wr(32'hC, 32'd1);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid reset tx", {31'd0, tx_o}, 32'd1);
    chk("mid reset oeb", {31'd0, tx_oeb}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wb_rd(32'h4, rd); chk("mid reset STATUS", rd, 32'h2);
    wb_rd(32'h8, rd); chk("mid reset DIV", rd, 32'h0000_00CF);
    wb_rd(32'hC, rd); chk("mid reset CTRL", rd, 32'h0);
    check_idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_uart_tx.md
# wb_uart_tx

Wishbone-slave UART transmitter instantiated inside the user project wrapper, between the management SoC's Wishbone bus (WB MI A) and one user IO pad. Firmware writes bytes into an 8-deep FIFO; a baud-rate FSM serialises them as 8N1 frames on `tx_o`, which the wrapper routes to `io_out`, with `tx_oeb_o` routed to `io_oeb`. `irq_o` drives one `user_irq` line and flags FIFO drained.

## Interface
- `BASE_ADR`, 32'h3000_0000, register window base; decode on `wbs_adr_i[31:4]`.
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two.
- `DIV_WIDTH`, 16, baud divisor width.
- `wb_clk_i`  in  1  sole clock; all logic rises on it.
- `wb_rst_ni`  in  1  reset, synchronous, active-low; wrapper drives it with `~wb_rst_i`.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone classic strobe/cycle/write.
- `wbs_sel_i`  in  4  byte lanes.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  acknowledge.
- `wbs_dat_o`  out  32  read data.
- `tx_o`  out  1  serial line, idle high.
- `tx_oeb_o`  out  1  pad output-enable, active-low.
- `irq_o`  out  1  level interrupt.

## Operation
- Registers (offset = `adr[3:2]`×4):
  - 0x0 DATA (W): push `dat[7:0]` if `sel[0]`; read returns 0.
  - 0x4 STATUS (R): [0] busy (FSM not IDLE), [1] empty, [2] full, [3] overflow sticky, [7:4] FIFO level; write 1 to bit 3 clears it.
  - 0x8 DIV (R/W): [DIV_WIDTH-1:0]; bit period = DIV+1 cycles; reset 16'd207.
  - 0xC CTRL (R/W): [0] enable, [1] irq_en; reset 0.
  - Unused read bits return 0.
- Push while FIFO full (full as registered before the edge, even if a pop occurs that cycle): byte dropped, overflow set.
- FSM IDLE → START → DATA (8 bits, LSB first) → STOP → IDLE, or STOP → START directly if enable && !empty (no idle gap). Each state lasts DIV+1 cycles via down-counter reloaded at every bit boundary.
- IDLE: when enable && !empty, pop byte into shift register, enter START, drive `tx_o`=0.
- DIV written mid-frame: takes effect at next bit-boundary reload.
- enable cleared mid-frame: current frame completes; no further pops. FIFO contents retained.
- `tx_oeb_o` = ~enable (registered). `irq_o` = irq_en && empty && FSM IDLE (registered).
- Reset mid-frame: FSM to IDLE, FIFO flushed, all registers to reset values, `tx_o`=1 next edge.

## Timing
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `tx_o`=1, `tx_oeb_o`=1, `irq_o`=0.
- Wishbone: request = stb && cyc && address match. `wbs_ack_o` is high exactly one cycle, on the cycle after the request; never asserted on consecutive cycles. Non-matching addresses never acked.
- Write side effects commit on the edge that raises ack; `wbs_dat_o` valid while ack high, 0 otherwise.
- DATA write to empty FIFO with FSM IDLE, enable=1: `tx_o` falls one cycle after ack.
- Frame length 10×(DIV+1) cycles; stop bit high for full DIV+1.

## Structure
- Package `wb_uart_pkg`: register offsets, STATUS bit indices, FSM state enum (IDLE, START, DATA, STOP), DIV and CTRL reset constants.
- Sub-module `wb_uart_fifo`: synchronous FIFO (push/pop/full/empty/level), parameterised by depth and width 8; same clock and reset.
- Top holds Wishbone decode, registers, baud counter, FSM.

## Test plan
- Reset: hold `wb_rst_ni`=0 2 cycles → all outputs at reset values; read DIV = 0x00CF, CTRL = 0.
- DIV=3, CTRL=1, write 0xA5 → `tx_o` low 1 cycle after ack, then bits 1,0,1,0,0,1,0,1, stop; each 4 cycles; 40 cycles total.
- Write 9 bytes with enable=0 → STATUS reads full=1, level=8, overflow=1; write 0x8 to STATUS → overflow=0.
- enable=1, 3 queued bytes, DIV=0 → 30 contiguous bit cycles, no idle between frames.
- CTRL=3, single byte → `irq_o`=0 during frame, 1 within 2 cycles after stop ends; clear irq_en → `irq_o`=0.
- Access to BASE_ADR+0x10 → no ack; reset asserted mid-DATA bit → `tx_o`=1, busy=0, level=0.
